// File: rtl/rr_arbiter8_encoded.sv
// rr_arbiter8_encoded
//   Round-robin arbiter for 8 requesters in front of a shared mux/encoder
//   datapath. Emits a registered one-hot grant together with its encoded
//   index so the downstream mux select needs no extra encoding logic.
//   A grant is held while the owner keeps requesting, optionally cut off
//   after MAX_HOLD cycles (0 = unlimited). Every release is followed by one
//   dead cycle before the next grant so the mux has time to turn around.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   enable       low blocks new grants and revokes the current one
//   req[7:0]     request vector, bit n = requester n
//   grant[7:0]   one-hot grant (registered)
//   grant_idx    encoded index of grant, 0 when idle (registered)
//   grant_valid  grant is non-zero (registered)
//   preempted    one-cycle pulse when the hold limit revoked the grant
module rr_arbiter8_encoded #(
    parameter int MAX_HOLD = 16,
    parameter int HOLD_W   = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [7:0] req,
    output logic [7:0] grant,
    output logic [2:0] grant_idx,
    output logic       grant_valid,
    output logic       preempted
);

    typedef enum logic {IDLE, GRANT} state_t;

    // Last hold count value before a forced release; unused when MAX_HOLD=0.
    localparam logic [HOLD_W-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : HOLD_W'(MAX_HOLD - 1);
    localparam logic [HOLD_W-1:0] HOLD_SAT  = '1;

    state_t            state;
    logic [2:0]        ptr;
    logic [HOLD_W-1:0] hold_cnt;

    logic       win_found;
    logic [2:0] win_idx;
    logic [2:0] cand;
    logic       owner_req;
    logic       hold_hit;
    logic       release_now;

    // Rotating scan: first set request at or after ptr, wrapping 7 -> 0.
    always_comb begin
        win_found = 1'b0;
        win_idx   = ptr;
        cand      = ptr;
        for (int i = 0; i < 8; i++) begin
            cand = ptr + 3'(i);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign owner_req   = req[grant_idx];
    assign hold_hit    = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);
    assign release_now = !enable || !owner_req || hold_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ptr         <= 3'd0;
            hold_cnt    <= '0;
            grant       <= 8'h00;
            grant_idx   <= 3'd0;
            grant_valid <= 1'b0;
            preempted   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    preempted <= 1'b0;
                    if (enable && win_found) begin
                        grant       <= 8'(1) << win_idx;
                        grant_idx   <= win_idx;
                        grant_valid <= 1'b1;
                        hold_cnt    <= '0;
                        state       <= GRANT;
                    end
                end
                GRANT: begin
                    if (release_now) begin
                        grant       <= 8'h00;
                        grant_idx   <= 3'd0;
                        grant_valid <= 1'b0;
                        // Just-released owner becomes lowest priority.
                        ptr         <= grant_idx + 3'd1;
                        state       <= IDLE;
                        // Only a pure hold-limit cut-off counts as preemption.
                        preempted   <= enable && owner_req;
                    end else begin
                        preempted <= 1'b0;
                        if (hold_cnt != HOLD_SAT) hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rr_arbiter8_encoded.sv
module tb_rr_arbiter8_encoded;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en_a, en_b;
    logic [7:0] req_a, req_b;
    logic [7:0] grant_a, grant_b;
    logic [2:0] idx_a, idx_b;
    logic       valid_a, valid_b, pre_a, pre_b;

    int checks = 0;
    int errors = 0;

    // Expected {grant, grant_idx, grant_valid, preempted}, one per clock step.
    logic [12:0] sb[$];

    always #5 clk = ~clk;

    rr_arbiter8_encoded #(.MAX_HOLD(16), .HOLD_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .enable(en_a), .req(req_a),
        .grant(grant_a), .grant_idx(idx_a), .grant_valid(valid_a), .preempted(pre_a)
    );

    rr_arbiter8_encoded #(.MAX_HOLD(0), .HOLD_W(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .enable(en_b), .req(req_b),
        .grant(grant_b), .grant_idx(idx_b), .grant_valid(valid_b), .preempted(pre_b)
    );

    function automatic logic [12:0] gv(input int idx, input bit pre);
        logic [7:0] g;
        logic [2:0] i3;
        i3 = 3'(idx);
        g  = 8'h01 << i3;
        return {g, i3, 1'b1, pre};
    endfunction

    function automatic logic [12:0] iv(input bit pre);
        return {8'h00, 3'd0, 1'b0, pre};
    endfunction

    task automatic cmp(input string tag, input logic [12:0] got, input logic [12:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Push the expectation for the coming edge, clock, then pop and compare.
    task automatic step(input string tag, input bit use_b, input logic [12:0] exp);
        logic [12:0] e;
        sb.push_back(exp);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        cmp(tag, use_b ? {grant_b, idx_b, valid_b, pre_b} : {grant_a, idx_a, valid_a, pre_a}, e);
    endtask

    // Short async reset pulse between edges (called at posedge+1).
    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        cmp("async_reset_a", {grant_a, idx_a, valid_a, pre_a}, iv(0));
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        en_a = 1'b0; en_b = 1'b0;
        req_a = 8'h00; req_b = 8'h00;
        #12;
        cmp("reset_a", {grant_a, idx_a, valid_a, pre_a}, iv(0));
        cmp("reset_b", {grant_b, idx_b, valid_b, pre_b}, iv(0));
        rst_n = 1'b1;

        // Test 1: single request, one-clock latency, release moves ptr to 3
        en_a = 1'b1; req_a = 8'b0000_0100;
        step("t1_grant2", 0, gv(2, 0));
        req_a = 8'h00;
        step("t1_release", 0, iv(0));
        step("t1_idle", 0, iv(0));

        // Test 2: wrap scan from 3 picks bit 0, then from 1 picks bit 2
        req_a = 8'b0000_0101;
        step("t2_grant0", 0, gv(0, 0));
        req_a = 8'h00;
        step("t2_release0", 0, iv(0));
        req_a = 8'b0000_0101;
        step("t2_grant2", 0, gv(2, 0));
        req_a = 8'h00;
        step("t2_release2", 0, iv(0));

        // Test 3: all requesting, hold limit 16, rotation 0..7,0
        pulse_reset();
        req_a = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            for (int c = 0; c < 16; c++) step($sformatf("t3_hold_g%0d_c%0d", k, c), 0, gv(k % 8, 0));
            step($sformatf("t3_preempt_g%0d", k), 0, iv(1));
        end

        // Test 4: enable drop revokes without preempt, blocks grants, ptr=6
        pulse_reset();
        req_a = 8'h20;
        step("t4_grant5", 0, gv(5, 0));
        en_a = 1'b0; req_a = 8'hFF;
        step("t4_revoke", 0, iv(0));
        for (int c = 0; c < 3; c++) step($sformatf("t4_blocked_%0d", c), 0, iv(0));
        en_a = 1'b1;
        step("t4_grant6", 0, gv(6, 0));

        // Test 5: async reset mid-grant on idx 4, ptr back to 0
        pulse_reset();
        req_a = 8'h10;
        step("t5_grant4", 0, gv(4, 0));
        step("t5_hold4", 0, gv(4, 0));
        pulse_reset();
        step("t5_regrant4", 0, gv(4, 0));
        req_a = 8'h00;
        step("t5_release", 0, iv(0));

        // Test 6: unlimited hold keeps requester 1 for 300 cycles
        cmp("t6_b_idle", {grant_b, idx_b, valid_b, pre_b}, iv(0));
        en_b = 1'b1; req_b = 8'h02;
        step("t6_grant1", 1, gv(1, 0));
        req_b = 8'hFF;
        for (int c = 0; c < 300; c++) step($sformatf("t6_hold_%0d", c), 1, gv(1, 0));
        checks++;
        assert (dut_b.hold_cnt === 8'hFF) else begin
            errors++;
            $error("FAIL t6_hold_sat observed=%h expected=ff", dut_b.hold_cnt);
        end
        req_b = 8'h00;
        step("t6_release", 1, iv(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_arbiter8_encoded.md
Name: rr_arbiter8_encoded

Overview:
- Round-robin arbiter sharing one resource among 8 requesters.
- Issues a one-hot grant plus the matching 3-bit encoded index, so the downstream mux select is driven directly.
- Sits in front of the shared mux/encoder datapath and sequences which requester owns it.
- Grants are held while the owner keeps requesting, with optional forced rotation after a hold limit.

Parameters:
- MAX_HOLD, 16, max consecutive cycles one requester may hold the grant; 0 = unlimited.
- HOLD_W, 8, width of the hold counter; must satisfy MAX_HOLD <= 2**HOLD_W.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous, active-low.
- enable  input  1  arbitration enable; low blocks new grants and revokes the current one.
- req  input  8  request vector; bit n = requester n.
- grant  output  8  one-hot grant, registered.
- grant_idx  output  3  encoded index of the granted bit, registered.
- grant_valid  output  1  high when grant is non-zero.
- preempted  output  1  one-cycle pulse when a grant is revoked by the hold limit.

Behaviour:
- Single clock domain. Every output is a register.
- Reset (rst_n low, asynchronous, takes effect immediately):
  - outputs: grant=8'h00, grant_idx=3'd0, grant_valid=0, preempted=0.
  - internal: ptr=3'd0, hold_cnt=0, state=IDLE.
- Two states: IDLE and GRANT.
- IDLE:
  - If enable=1 and req!=0: scan req starting at bit ptr, ascending, wrapping 7->0; the first set bit n wins.
  - At the next edge: grant=1<<n, grant_idx=n, grant_valid=1, hold_cnt=0, state=GRANT.
  - Latency is exactly one clock from request sampled to grant visible.
  - If enable=0 or req=0: stay in IDLE, all outputs 0, ptr unchanged.
- GRANT:
  - Each cycle hold_cnt increments and saturates at its maximum.
  - Release conditions, evaluated in priority order:
    - (a) enable=0;
    - (b) req[grant_idx]=0;
    - (c) MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1.
  - On release, at the next edge:
    - grant=0, grant_valid=0, grant_idx=0;
    - ptr=(grant_idx+1) mod 8, with wrap from 7 to 0;
    - state=IDLE.
  - preempted=1 for one cycle only if the release cause is (c) alone, i.e. enable=1 and the owner still requests.
  - Otherwise preempted=0.
  - A held grant therefore lasts at most MAX_HOLD cycles.
  - Every release is followed by exactly one dead cycle (grant=0) before the next grant; this is required for mux turnaround.
- Requests from non-owners during GRANT are ignored; they are not latched.
- Fairness:
  - The just-released requester has the lowest priority in the next scan.
  - With all 8 requesting continuously, grants rotate 0,1,...,7,0,...
- grant is never multi-hot. grant_idx always equals the encoded position of grant, and equals 0 when grant_valid=0.
- Reset asserted mid-grant: outputs clear immediately without waiting for a clock edge, and ptr returns to 0.
- req changing in the same cycle as a release does not alter that release; the new req is sampled in the following IDLE cycle.

Test Plan:
1. Reset, then req=8'b0000_0100, enable=1 -> one clock later grant=8'h04, grant_idx=2, grant_valid=1; drop req -> next edge grant=0, and ptr=3 is observable through the next scan.
2. After test 1 (ptr=3), req=8'b0000_0101 -> grant_idx=0, because the wrap scan from 3 finds bit 0 before bit 2; release; req=8'b0000_0101 again -> grant_idx=2.
3. MAX_HOLD=16, req=8'hFF held -> each grant lasts 16 cycles, then preempted pulse, 1 dead cycle; grant_idx sequence is 0,1,2,...,7,0.
4. While in GRANT on idx 5, enable=0 -> next edge grant=0, preempted=0; with enable held 0 and req=8'hFF, no grant is issued; enable=1 -> grant_idx=6.
5. rst_n pulsed low mid-grant (idx 4) -> outputs go to 0 asynchronously, before the next clk edge; after release with req=8'h10 -> grant_idx=4, since ptr=0.
6. MAX_HOLD=0, req[1] held for 300 cycles while req=8'hFF -> grant stays 8'h02 throughout, hold_cnt saturates, preempted never asserts.
